btb_update_queue: RTL and testbench

- Sits between branch resolution in execute and the branch target buffer's update port.
- Buffers resolved-mispredict target updates in a small FIFO and coalesces repeat updates to the same PC.
- Presents at most one update per cycle to the BTB, stalling while the BTB write port is busy (FPGA dual-port contention).
- Absorbs bursts of mispredicts without back-pressuring execute; drops and counts updates on overflow.

---
 rtl/btb_update_queue_pkg.sv | 21 ++
 rtl/btb_update_queue.sv | 121 ++++++++++++
 tb/tb_btb_update_queue.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/btb_update_queue_pkg.sv
// Types shared by the BTB update queue: the core-config subset it needs, the
// BTB update record and the default queue depth.
package btb_update_queue_pkg;

   localparam int unsigned BTB_VLEN = 32;

   typedef struct packed {
      int unsigned VLEN;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: BTB_VLEN};

   typedef struct packed {
      logic                valid;
      logic [BTB_VLEN-1:0] pc;
      logic [BTB_VLEN-1:0] target_address;
   } btb_update_t;

   localparam int unsigned BTB_UPDQ_DEPTH = 4;

endpackage

// File: rtl/btb_update_queue.sv
// Coalescing FIFO between branch resolution and the BTB update port. Repeat
// mispredicts on a queued PC overwrite its target in place; overflow drops are counted.
module btb_update_queue
   import btb_update_queue_pkg::*;
#(
   parameter cva6_cfg_t   CVA6Cfg    = cva6_cfg_empty,
   parameter int unsigned DEPTH      = BTB_UPDQ_DEPTH,
   parameter int unsigned DROP_CNT_W = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_bp_i,
   input  logic                    debug_mode_i,
   input  logic                    res_valid_i,
   input  logic                    res_mispredict_i,
   input  logic [CVA6Cfg.VLEN-1:0] res_pc_i,
   input  logic [CVA6Cfg.VLEN-1:0] res_target_i,
   input  logic                    btb_ready_i,
   output btb_update_t             btb_update_o,
   output logic [DROP_CNT_W-1:0]   drop_cnt_o
);

   localparam int unsigned VW    = CVA6Cfg.VLEN;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + DROP_CNT_W'(1);
   endfunction

   logic [VW-1:0]         r_pc  [DEPTH];
   logic [VW-1:0]         r_tgt [DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [OCC_W-1:0]      r_occ;
   logic [DROP_CNT_W-1:0] r_drop_cnt;

   logic [DEPTH-1:0]      w_entry_vld;
   logic [DEPTH-1:0]      w_match;
   logic                  w_vld;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_hit;
   logic                  w_head_hit;
   logic                  w_coalesce;
   logic                  w_enq;
   logic                  w_drop;

   assign w_vld  = (r_occ != '0);
   assign w_full = (r_occ == OCC_W'(DEPTH));
   assign w_push = res_valid_i & res_mispredict_i & ~debug_mode_i & ~flush_bp_i;
   assign w_pop  = w_vld & btb_ready_i;

   // An entry is live when its distance from the head is below the occupancy.
   always_comb begin
      w_entry_vld = '0;
      w_match     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_entry_vld[i] = ({1'b0, PTR_W'(i) - r_rd_ptr}) < r_occ;
         w_match[i]     = w_entry_vld[i] & (r_pc[i] == res_pc_i);
      end
   end

   assign w_hit      = |w_match;
   assign w_head_hit = w_match[r_rd_ptr];

   // A hit on the head that is leaving this cycle must be re-enqueued, or its newer target is lost.
   assign w_coalesce = w_push & w_hit & ~(w_head_hit & w_pop);
   assign w_enq      = w_push & ~w_coalesce & (~w_full | w_pop);
   assign w_drop     = w_push & ~w_coalesce & w_full & ~w_pop;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_occ    <= '0;
      end else if (flush_bp_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         r_occ <= r_occ + OCC_W'(w_enq) - OCC_W'(w_pop);
      end
   end

   // The drop count survives a predictor flush; only reset clears it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_drop_cnt <= sat_inc(r_drop_cnt);
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (w_enq && (r_wr_ptr == PTR_W'(i))) begin
            r_pc[i]  <= res_pc_i;
            r_tgt[i] <= res_target_i;
         end else if (w_coalesce && w_match[i]) begin
            r_tgt[i] <= res_target_i;
         end
      end
   end

   // Stale storage is masked so an idle port always reads zero.
   always_comb begin
      btb_update_o       = '0;
      btb_update_o.valid = w_vld;
      if (w_vld) begin
         btb_update_o.pc             = r_pc[r_rd_ptr];
         btb_update_o.target_address = r_tgt[r_rd_ptr];
      end
   end

   assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed plus randomized bench for btb_update_queue, checked cycle by cycle
// against a queue-based reference model.
module tb_btb_update_queue;
   import btb_update_queue_pkg::*;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned DW      = 8;
   localparam int unsigned DROPMAX = (1 << DW) - 1;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              flush_bp_i;
   logic              debug_mode_i;
   logic              res_valid_i;
   logic              res_mispredict_i;
   logic [31:0]       res_pc_i;
   logic [31:0]       res_target_i;
   logic              btb_ready_i;
   btb_update_t       btb_update_o;
   logic [DW-1:0]     drop_cnt_o;

   btb_update_queue #(
      .CVA6Cfg   (cva6_cfg_empty),
      .DEPTH     (DEPTH),
      .DROP_CNT_W(DW)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .flush_bp_i      (flush_bp_i),
      .debug_mode_i    (debug_mode_i),
      .res_valid_i     (res_valid_i),
      .res_mispredict_i(res_mispredict_i),
      .res_pc_i        (res_pc_i),
      .res_target_i    (res_target_i),
      .btb_ready_i     (btb_ready_i),
      .btb_update_o    (btb_update_o),
      .drop_cnt_o      (drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] tgt;
   } ent_t;

   ent_t        mq[$];
   int unsigned m_drop;
   int          n_chk;
   int          n_pass;
   int          n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      logic        ev;
      logic [31:0] epc;
      logic [31:0] etgt;
      ev   = (mq.size() != 0);
      epc  = 32'h0;
      etgt = 32'h0;
      if (ev) begin
         epc  = mq[0].pc;
         etgt = mq[0].tgt;
      end
      chk({tag, ".valid"}, 32'(btb_update_o.valid), 32'(ev));
      chk({tag, ".pc"}, btb_update_o.pc, epc);
      chk({tag, ".tgt"}, btb_update_o.target_address, etgt);
      chk({tag, ".drop"}, 32'(drop_cnt_o), m_drop);
   endtask

   // Reference behaviour: a list of {pc,target} in arrival order.
   task automatic model_step(input bit v, input bit mp, input bit dbg, input bit fl,
                             input bit rdy, input logic [31:0] pc, input logic [31:0] tgt);
      bit   push;
      bit   pop;
      int   hit;
      ent_t e;
      push = v && mp && !dbg && !fl;
      pop  = (mq.size() != 0) && rdy;
      hit  = -1;
      if (fl) begin
         mq.delete();
         return;
      end
      foreach (mq[i]) if (mq[i].pc == pc) hit = i;
      e.pc  = pc;
      e.tgt = tgt;
      if (push && hit >= 0 && !(hit == 0 && pop)) begin
         mq[hit].tgt = tgt;
         if (pop) void'(mq.pop_front());
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else if (m_drop < DROPMAX) m_drop++;
         end
      end
   endtask

   // Called at posedge+1; returns at the following posedge+1.
   task automatic cycle(input bit v, input bit mp, input bit dbg, input bit fl, input bit rdy,
                        input logic [31:0] pc, input logic [31:0] tgt, input string tag);
      res_valid_i      = v;
      res_mispredict_i = mp;
      debug_mode_i     = dbg;
      flush_bp_i       = fl;
      btb_ready_i      = rdy;
      res_pc_i         = pc;
      res_target_i     = tgt;
      #1;
      check_outs(tag);
      if (v && mp && !dbg && !fl)
         chk({tag, ".one_match"}, 32'($countones(dut.w_match) <= 1), 32'd1);
      model_step(v, mp, dbg, fl, rdy, pc, tgt);
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input bit rdy, input string tag);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, rdy, pc, tgt, tag);
   endtask

   task automatic idle(input bit rdy, input string tag);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, rdy, 32'h0, 32'h0, tag);
   endtask

   initial begin
      n_chk = 0; n_pass = 0; n_fail = 0; m_drop = 0;
      rst_ni = 1'b0; flush_bp_i = 1'b0; debug_mode_i = 1'b0;
      res_valid_i = 1'b0; res_mispredict_i = 1'b0;
      res_pc_i = '0; res_target_i = '0; btb_ready_i = 1'b0;

      #1;
      chk("reset.valid", 32'(btb_update_o.valid), 32'd0);
      chk("reset.pc", btb_update_o.pc, 32'h0);
      chk("reset.tgt", btb_update_o.target_address, 32'h0);
      chk("reset.drop", 32'(drop_cnt_o), 32'd0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      // Single push, latency 1, then empty.
      push(32'h8000_0010, 32'h8000_0400, 1'b1, "single.c0");
      chk("single.c1.valid", 32'(btb_update_o.valid), 32'd1);
      chk("single.c1.pc", btb_update_o.pc, 32'h8000_0010);
      chk("single.c1.tgt", btb_update_o.target_address, 32'h8000_0400);
      idle(1'b1, "single.c1");
      chk("single.c2.valid", 32'(btb_update_o.valid), 32'd0);

      // Coalesce while stalled.
      push(32'h100, 32'h200, 1'b0, "coal.a");
      push(32'h100, 32'h300, 1'b0, "coal.b");
      chk("coal.tgt", btb_update_o.target_address, 32'h300);
      idle(1'b1, "coal.pop");
      chk("coal.one_entry", 32'(btb_update_o.valid), 32'd0);

      // Head-pop race.
      push(32'h100, 32'h200, 1'b0, "race.a");
      push(32'h100, 32'h500, 1'b1, "race.b");
      chk("race.valid", 32'(btb_update_o.valid), 32'd1);
      chk("race.pc", btb_update_o.pc, 32'h100);
      chk("race.tgt", btb_update_o.target_address, 32'h500);
      idle(1'b1, "race.pop");
      chk("race.occ1", 32'(btb_update_o.valid), 32'd0);

      // Overflow: six distinct PCs into four slots.
      for (int k = 0; k < 6; k++) push(32'h1000 + 32'(16 * k), 32'h2000 + 32'(k), 1'b0, "ovf.fill");
      chk("ovf.drop2", 32'(drop_cnt_o), 32'd2);
      for (int k = 0; k < 4; k++) begin
         chk("ovf.drain.pc", btb_update_o.pc, 32'h1000 + 32'(16 * k));
         idle(1'b1, "ovf.drain");
      end
      chk("ovf.empty", 32'(btb_update_o.valid), 32'd0);

      // Flush with three entries queued and a simultaneous push.
      for (int k = 0; k < 3; k++) push(32'h5000 + 32'(4 * k), 32'h5100 + 32'(k), 1'b0, "flush.fill");
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h6000, 32'h6100, "flush.cyc");
      chk("flush.valid", 32'(btb_update_o.valid), 32'd0);
      chk("flush.drop", 32'(drop_cnt_o), 32'd2);

      // Debug mode: pushes ignored, queued entries still drain.
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h7700, 32'h7800, "dbg.push");
      chk("dbg.valid", 32'(btb_update_o.valid), 32'd0);
      push(32'h7a00, 32'h7b00, 1'b0, "dbg.fill");
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h7c00, 32'h7d00, "dbg.drain");
      chk("dbg.drained", 32'(btb_update_o.valid), 32'd0);

      // Wrap-around at full rate.
      for (int k = 0; k < 10; k++) begin
         push(32'h9000 + 32'(4 * k), 32'ha000 + 32'(k), 1'b1, "wrap");
         chk("wrap.pc", btb_update_o.pc, 32'h9000 + 32'(4 * k));
      end
      idle(1'b1, "wrap.end");

      // Randomized traffic over a small PC set to exercise coalescing.
      for (int k = 0; k < 600; k++) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
               1'($urandom_range(0, 1)),
               32'h1000 + 32'(4 * $urandom_range(0, 7)), $urandom, "rand");
      end

      // Saturation of the drop counter.
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "sat.flush");
      for (int k = 0; k < 4; k++) push(32'h3000 + 32'(4 * k), 32'h3100, 1'b0, "sat.fill");
      for (int k = 0; k < 300; k++) push(32'h4000 + 32'(4 * k), 32'h4100, 1'b0, "sat.drop");
      chk("sat.drop255", 32'(drop_cnt_o), 32'd255);
      for (int k = 0; k < 4; k++) idle(1'b1, "sat.drain");

      // Asynchronous reset mid-operation.
      push(32'hb000, 32'hb100, 1'b0, "arst.fill");
      push(32'hb004, 32'hb104, 1'b0, "arst.fill");
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst.valid", 32'(btb_update_o.valid), 32'd0);
      chk("arst.pc", btb_update_o.pc, 32'h0);
      chk("arst.drop", 32'(drop_cnt_o), 32'd0);
      mq.delete();
      m_drop = 0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      push(32'hc000, 32'hc100, 1'b1, "arst.after");
      idle(1'b1, "arst.after");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
